// File: rtl/dm_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder_pkg
//  Description : Shared encodings for the data-memory responder: access size
//                codes, FSM state codes and the latched request record.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_responder_pkg;

    // Access size codes carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Responder FSM state codes
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Request fields that are held from accept until the access executes
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/dm_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder_if
//  Description : Handshaked request/response bundle between the MEM stage
//                (master) and the data-memory responder (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface dm_responder_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dm_lane_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_lane_ctrl
//  Description : Combinational little-endian lane steering. Produces byte
//                enables, the merged write word, the extended load data and
//                the misalign/reserved-size flag.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_lane_ctrl
    import dm_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        misalign
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rword[{lane, 3'b000} +: 8];
    assign w_half = rword[{lane[1], 4'b0000} +: 16];

    // Lane selection; an error leaves be at zero so nothing gets written
    always_comb begin
        be       = 4'b0000;
        wword    = rword;
        ldata    = 32'd0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be                          = 4'b0001 << lane;
                wword[{lane, 3'b000} +: 8]  = wdata[7:0];
                ldata                       = {{24{sign_ext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                if (lane[0]) begin
                    misalign = 1'b1;
                end else begin
                    be                            = lane[1] ? 4'b1100 : 4'b0011;
                    wword[{lane[1], 4'b0000} +: 16] = wdata[15:0];
                    ldata                         = {{16{sign_ext & w_half[15]}}, w_half};
                end
            end
            SZ_WORD: begin
                if (lane != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    be    = 4'b1111;
                    wword = wdata;
                    ldata = rword;
                end
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder
//  Description : Handshaked multi-cycle data RAM serving byte/half/word
//                loads and stores, plus a combinational read-only display port.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W   = 6,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    dm_responder_if.slave     bus,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_word
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       mem [DEPTH];

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    req_t              r_req;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_rdata;
    logic              r_err;

    req_t              w_req;
    logic [ADDR_W+1:0] w_addr;
    logic [31:0]       w_rword;
    logic [3:0]        w_be;
    logic [31:0]       w_wword;
    logic [31:0]       w_ldata;
    logic              w_misalign;
    logic              w_accept;
    logic              w_enter_resp;
    logic              w_write;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // With zero wait states the access executes on the accept edge, before
    // the latch is loaded, so the live bus feeds the lane logic while idle.
    assign w_req  = (r_state == S_IDLE) ?
                    '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed, wdata: bus.req_wdata} :
                    r_req;
    assign w_addr = (r_state == S_IDLE) ? bus.req_addr : r_addr;

    assign w_rword = mem[w_addr[ADDR_W+1:2]];

    dm_lane_ctrl u_lane (
        .size     (w_req.size),
        .lane     (w_addr[1:0]),
        .sign_ext (w_req.sgn),
        .wdata    (w_req.wdata),
        .rword    (w_rword),
        .be       (w_be),
        .wword    (w_wword),
        .ldata    (w_ldata),
        .misalign (w_misalign)
    );

    assign w_enter_resp = (w_accept && (WAIT_CYC == 0)) ||
                          ((r_state == S_WAIT) && (r_cnt <= 4'd1));

    // Reset gates the write so a store caught mid-flight is never committed
    assign w_write = rst && w_enter_resp && w_req.we && (|w_be);

    // RAM write port; contents are deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (w_write) begin
            mem[w_addr[ADDR_W+1:2]] <= w_wword;
        end
    end

    // Request latch, wait counter, response capture and state sequencing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_req   <= '0;
            r_addr  <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_enter_resp) begin
                r_rdata <= (w_req.we || w_misalign) ? 32'd0 : w_ldata;
                r_err   <= w_misalign;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req   <= w_req;
                        r_addr  <= bus.req_addr;
                        r_cnt   <= 4'(WAIT_CYC);
                        r_state <= (WAIT_CYC == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    assign disp_word = mem[disp_addr];

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_responder
//  Description : Self-checking bench for dm_responder: directed table, hold
//                and reset sequences, randomized traffic against a byte-array
//                reference model, and a zero-wait-state instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_responder;
    import dm_responder_pkg::*;

    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if #(.ADDR_W(AW)) bus ();
    dm_responder_if #(.ADDR_W(AW)) bus0 ();

    logic [AW-1:0] disp_addr;
    logic [AW-1:0] disp_addr0;
    logic [31:0]   disp_word;
    logic [31:0]   disp_word0;

    dm_responder #(.ADDR_W(AW), .WAIT_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .disp_addr (disp_addr),
        .disp_word (disp_word)
    );

    dm_responder #(.ADDR_W(AW), .WAIT_CYC(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus0),
        .disp_addr (disp_addr0),
        .disp_word (disp_word0)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory as plain bytes, byte address = index
    logic [7:0] mb [256];

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mb[4*idx+3], mb[4*idx+2], mb[4*idx+1], mb[4*idx]};
    endfunction

    // Access defined by sizes in bytes and little-endian byte order
    function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                         input logic [7:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int     n;
        longint v;
        n     = 1 << size;
        err   = (size == 2'b11) || ((int'(addr) % n) != 0);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int k = 0; k < n; k++) mb[int'(addr) + k] = wdata[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (longint'(mb[int'(addr) + k]) << (8*k));
                if (sgn && v[8*n-1]) v = v - (longint'(1) << (8*n));
                rdata = v[31:0];
            end
        end
    endfunction

    // One full transaction on the WAIT_CYC=2 instance with rsp_ready held high
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int t;
        @(negedge clk);
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        bus.rsp_ready  = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 0;
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_size = 0; bus0.req_signed = 0;
        bus0.req_addr = 0; bus0.req_wdata = 0; bus0.rsp_ready = 0;
        disp_addr = 0; disp_addr0 = 0;

        vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 8'h04, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, SZ_BYTE, 1'b0, 8'h05, 32'h77777780, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0,        32'hDEAD80EF, 1'b0};
        vecs[4]  = '{1'b0, SZ_BYTE, 1'b1, 8'h05, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{1'b0, SZ_BYTE, 1'b0, 8'h05, 32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{1'b0, SZ_HALF, 1'b1, 8'h06, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[7]  = '{1'b0, SZ_HALF, 1'b0, 8'h06, 32'h0,        32'h0000DEAD, 1'b0};
        vecs[8]  = '{1'b1, SZ_WORD, 1'b0, 8'h00, 32'h01234567, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, SZ_HALF, 1'b0, 8'h03, 32'h0000BEEF, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, SZ_WORD, 1'b0, 8'h00, 32'h0,        32'h01234567, 1'b0};
        vecs[11] = '{1'b0, SZ_WORD, 1'b0, 8'h02, 32'h0,        32'h00000000, 1'b1};
        vecs[12] = '{1'b0, SZ_RSVD, 1'b0, 8'h08, 32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b0, SZ_HALF, 1'b1, 8'h04, 32'h0,        32'hFFFF80EF, 1'b0};
        vecs[14] = '{1'b1, SZ_HALF, 1'b0, 8'h06, 32'hAAAA1234, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, SZ_BYTE, 1'b1, 8'h07, 32'h0,        32'h00000012, 1'b0};
        vecs[16] = '{1'b1, SZ_BYTE, 1'b0, 8'hFF, 32'h000000AB, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 8'hFF, 32'h0,        32'h000000AB, 1'b0};
        vecs[18] = '{1'b0, SZ_BYTE, 1'b1, 8'hFF, 32'h0,        32'hFFFFFFAB, 1'b0};
        vecs[19] = '{1'b0, SZ_WORD, 1'b1, 8'h04, 32'h0,        32'h123480EF, 1'b0};

        // Reset values
        #12;
        check32("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check32("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
        check32("reset_rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        @(negedge clk) rst = 1'b1;

        // Fill RAM with known contents
        for (int w = 0; w < 64; w++) begin
            logic [31:0] d;
            d = $urandom;
            do_req(1'b1, SZ_WORD, 1'b0, 8'(w * 4), d, rd, er, lat);
            model_access(1'b1, SZ_WORD, 1'b0, 8'(w * 4), d, exp_rd, exp_er);
        end

        // Reset during WAIT discards the pending store
        @(negedge clk);
        bus.req_we = 1; bus.req_size = SZ_WORD; bus.req_signed = 0;
        bus.req_addr = 8'h08; bus.req_wdata = 32'h11223344; bus.req_valid = 1;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk) rst = 1'b0;
        #1;
        check32("midwait_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check32("midwait_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk) rst = 1'b1;
        disp_addr = 6'd2;
        @(negedge clk);
        check32("midwait_mem2", disp_word, model_word(2));

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            model_access(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, exp_rd, exp_er);
            check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check32($sformatf("vec%0d_latency", i), lat, 32'd3);
            disp_addr = vecs[i].addr[7:2];
            #1 check32($sformatf("vec%0d_disp", i), disp_word, model_word(int'(vecs[i].addr[7:2])));
        end

        // Response held while rsp_ready is low
        @(negedge clk);
        bus.req_we = 0; bus.req_size = SZ_WORD; bus.req_signed = 0;
        bus.req_addr = 8'h04; bus.req_valid = 1; bus.rsp_ready = 0;
        @(posedge clk);
        #1 bus.req_valid = 0;
        model_access(1'b0, SZ_WORD, 1'b0, 8'h04, 32'h0, exp_rd, exp_er);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        check32("hold_latency", lat, 32'd3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check32($sformatf("hold%0d_rsp_valid", c), {31'd0, bus.rsp_valid}, 32'd1);
            check32($sformatf("hold%0d_rdata", c), bus.rsp_rdata, exp_rd);
            check32($sformatf("hold%0d_req_ready", c), {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1;
        @(posedge clk);
        #1;
        check32("release_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check32("release_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // Reset during RESP keeps a committed store
        @(negedge clk);
        bus.req_we = 1; bus.req_size = SZ_WORD; bus.req_addr = 8'h10;
        bus.req_wdata = 32'h5A5A0F0F; bus.req_valid = 1; bus.rsp_ready = 0;
        @(posedge clk);
        #1 bus.req_valid = 0;
        model_access(1'b1, SZ_WORD, 1'b0, 8'h10, 32'h5A5A0F0F, exp_rd, exp_er);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        rst = 1'b0;
        #1 check32("respreset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(negedge clk) rst = 1'b1;
        disp_addr = 6'd4;
        #1 check32("respreset_mem4", disp_word, model_word(4));

        // Randomized traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [7:0]  addr;
            logic [31:0] wd;
            we   = 1'($urandom_range(0, 1));
            sgn  = 1'($urandom_range(0, 1));
            size = 2'($urandom_range(0, 3));
            addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0 && size != SZ_RSVD) addr = addr & ~(8'((1 << size) - 1));
            wd   = $urandom;
            do_req(we, size, sgn, addr, wd, rd, er, lat);
            model_access(we, size, sgn, addr, wd, exp_rd, exp_er);
            check32($sformatf("rand%0d_rdata", i), rd, exp_rd);
            check32($sformatf("rand%0d_err", i), {31'd0, er}, {31'd0, exp_er});
            check32($sformatf("rand%0d_latency", i), lat, 32'd3);
        end
        for (int w = 0; w < 64; w++) begin
            disp_addr = 6'(w);
            #1 check32($sformatf("final_mem%0d", w), disp_word, model_word(w));
        end

        // Zero-wait-state instance: store then load, one-cycle latency each
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus0.req_we = (i == 0); bus0.req_size = SZ_WORD; bus0.req_signed = 0;
            bus0.req_addr = 8'h0C; bus0.req_wdata = 32'hCAFE1234;
            bus0.req_valid = 1; bus0.rsp_ready = 1;
            @(posedge clk);
            #1 bus0.req_valid = 0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!bus0.rsp_valid && lat < 20);
            check32($sformatf("w0_op%0d_latency", i), lat, 32'd1);
            check32($sformatf("w0_op%0d_rdata", i), bus0.rsp_rdata, (i == 0) ? 32'd0 : 32'hCAFE1234);
            check32($sformatf("w0_op%0d_err", i), {31'd0, bus0.rsp_err}, 32'd0);
            @(posedge clk);
            #1;
        end
        disp_addr0 = 6'd3;
        #1 check32("w0_disp", disp_word0, 32'hCAFE1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
